div_iter: RTL and testbench

- Iterative integer divider; the responder end of the execute stage's divide interface.
- Accepts requests on es_to_div_bus and returns {div_result, div_ok} on div_to_es_bus.
- Radix-2^RADIX_BITS restoring divider on operand magnitudes, followed by a sign fix-up.
- Sits beside the execute stage; the execute stage stalls until div_ok.

---
 rtl/div_iter_if.sv | 9 +
 rtl/div_iter.sv | 94 +++++++++
 tb/tb_div_iter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/div_iter_if.sv
// div_iter_if: execute-stage <-> divider handshake bundle
interface div_iter_if;
  logic [66:0] es_to_div_bus;
  logic        div_ack;
  logic [32:0] div_to_es_bus;
  logic        div_busy;
  modport master (output es_to_div_bus, div_ack, input div_to_es_bus, div_busy);
  modport slave (input es_to_div_bus, div_ack, output div_to_es_bus, div_busy);
endinterface

// File: rtl/div_iter.sv
// div_iter: radix-2^RADIX_BITS restoring divider with sign fix-up; DIV_FAST_PATH_EN enables the early-out for trivial operands
module div_iter #(
  parameter int RADIX_BITS = 1
) (
  input logic       clk,
  input logic       reset,
  input logic       flush,
  div_iter_if.slave bus
);
  localparam int N = 32 / RADIX_BITS;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t      r_state;
  logic [5:0]  r_cnt;
  logic        r_use_mod, r_sign_q, r_sign_r, r_dz, r_ok;
  logic [31:0] r_rem, r_quo, r_dsr, r_dvd, r_result;
  logic        w_req, w_mod, w_uns, w_sx, w_sy, w_fast;
  logic [31:0] w_a, w_b, w_abs_a, w_abs_b, w_rem, w_quo, w_final, w_fast_res;
  logic [32:0] w_t;
  assign {w_req, w_mod, w_uns, w_a, w_b} = bus.es_to_div_bus;
  assign w_sx = ~w_uns & w_a[31];
  assign w_sy = ~w_uns & w_b[31];
  assign w_abs_a = w_sx ? -w_a : w_a;
  assign w_abs_b = w_sy ? -w_b : w_b;
`ifdef DIV_FAST_PATH_EN
  assign w_fast = (w_b == '0) || (w_abs_a < w_abs_b);
  assign w_fast_res = w_mod ? w_a : {32{w_b == '0}};
`else
  assign w_fast = 1'b0;
  assign w_fast_res = '0;
`endif
  // RADIX_BITS restoring steps on {remainder, quotient shift register}
  always_comb begin
    w_rem = r_rem;
    w_quo = r_quo;
    w_t = '0;
    for (int k = 0; k < RADIX_BITS; k++) begin
      w_t = {w_rem, w_quo[31]};
      w_quo = {w_quo[30:0], w_t >= {1'b0, r_dsr}};
      w_rem = w_t >= {1'b0, r_dsr} ? 32'(w_t - {1'b0, r_dsr}) : w_t[31:0];
    end
  end
  assign w_final = r_dz ? (r_use_mod ? r_dvd : '1) :
                   r_use_mod ? (r_sign_r ? -w_rem : w_rem) : (r_sign_q ? -w_quo : w_quo);
  assign bus.div_to_es_bus = {r_result, r_ok};
  assign bus.div_busy = r_state != IDLE;
  // IDLE/BUSY/DONE control with registered result and div_ok
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_state <= IDLE;
      r_ok <= 1'b0;
      r_result <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_req) begin
          r_use_mod <= w_mod;
          r_dvd <= w_a;
          r_dsr <= w_abs_b;
          r_dz <= w_b == '0;
          r_rem <= '0;
          r_quo <= w_abs_a;
          r_sign_q <= w_sx ^ w_sy;
          r_sign_r <= w_sx;
          if (w_fast) begin
            r_result <= w_fast_res;
            r_ok <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= 6'(N);
            r_state <= BUSY;
          end
        end
        BUSY: if (!w_req) begin
          r_cnt <= '0;
          r_state <= IDLE;
        end else begin
          r_rem <= w_rem;
          r_quo <= w_quo;
          r_cnt <= r_cnt - 6'd1;
          if (r_cnt == 6'd1) begin
            r_result <= w_final;
            r_ok <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: if (bus.div_ack || !w_req) begin
          r_ok <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed and random divides checked against a scoreboard
module tb_div_iter;
  logic clk = 1'b0;
  logic reset, flush;
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] sb[$];
  int lq[$];
  div_iter_if bus();
  div_iter #(.RADIX_BITS(1)) dut (.clk(clk), .reset(reset), .flush(flush), .bus(bus.slave));
  always #5 clk = ~clk;
  wire        ok  = bus.div_to_es_bus[0];
  wire [31:0] res = bus.div_to_es_bus[32:1];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] model(input bit m, input bit u, input logic [31:0] a, input logic [31:0] b);
    int sa, sb_;
    if (b == 0) return m ? a : 32'hFFFF_FFFF;
    if (u) return m ? a % b : a / b;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return m ? 32'h0 : 32'h8000_0000;
    sa = $signed(a);
    sb_ = $signed(b);
    return m ? 32'(sa % sb_) : 32'(sa / sb_);
  endfunction
  function automatic int lat_of(input bit u, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_FAST_PATH_EN
    logic [31:0] ma, mb;
    ma = (!u && a[31]) ? -a : a;
    mb = (!u && b[31]) ? -b : b;
    if (b == 0 || ma < mb) return 1;
`endif
    return 32;
  endfunction
  task automatic issue(input bit m, input bit u, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    @(negedge clk);
    bus.es_to_div_bus = {1'b1, m, u, a, b};
    sb.push_back(exp);
    lq.push_back(lat_of(u, a, b));
  endtask
  task automatic collect(input string tag);
    int cyc = 0;
    int lat;
    logic [31:0] exp;
    do begin
      @(negedge clk);
      cyc++;
    end while (!ok && cyc < 100);
    lat = lq.pop_front();
    exp = sb.pop_front();
    chk({tag, "_latency"}, 32'(cyc), 32'(lat + 1));
    chk(tag, res, exp);
    chk({tag, "_busy"}, bus.div_busy, 1);
  endtask
  task automatic retire(input string tag);
    bus.div_ack = 1'b1;
    bus.es_to_div_bus[66] = 1'b0;
    @(negedge clk);
    bus.div_ack = 1'b0;
    chk({tag, "_ok_clr"}, ok, 0);
    chk({tag, "_idle"}, bus.div_busy, 0);
  endtask
  initial begin
    logic [31:0] ra, rb, held;
    bit rm, ru;
    reset = 1'b1;
    flush = 1'b0;
    bus.es_to_div_bus = '0;
    bus.div_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ok", ok, 0);
    chk("rst_result", res, 0);
    chk("rst_busy", bus.div_busy, 0);
    reset = 1'b0;
    issue(0, 1, 100, 7, 14);
    collect("u100div7");
    retire("u100div7");
    issue(1, 1, 100, 7, 2);
    collect("u100mod7");
    retire("u100mod7");
    issue(0, 0, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD);
    collect("s_m7div2");
    retire("s_m7div2");
    issue(1, 0, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF);
    collect("s_m7mod2");
    retire("s_m7mod2");
    issue(0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    collect("ovf_div");
    retire("ovf_div");
    issue(1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    collect("ovf_mod");
    retire("ovf_mod");
    issue(0, 0, 32'h1234_5678, 0, 32'hFFFF_FFFF);
    collect("dz_s_div");
    retire("dz_s_div");
    issue(1, 0, 32'h1234_5678, 0, 32'h1234_5678);
    collect("dz_s_mod");
    retire("dz_s_mod");
    issue(0, 1, 32'h1234_5678, 0, 32'hFFFF_FFFF);
    collect("dz_u_div");
    retire("dz_u_div");
    issue(1, 1, 32'h1234_5678, 0, 32'h1234_5678);
    collect("dz_u_mod");
    retire("dz_u_mod");
    issue(0, 1, 100, 7, 14);
    repeat (10) begin
      @(negedge clk);
      chk("flush_no_ok", ok, 0);
    end
    flush = 1'b1;
    bus.es_to_div_bus = {1'b1, 1'b0, 1'b1, 32'd9, 32'd3};
    void'(sb.pop_back());
    void'(lq.pop_back());
    sb.push_back(32'd3);
    lq.push_back(lat_of(1, 9, 3));
    @(negedge clk);
    flush = 1'b0;
    chk("flush_idle", bus.div_busy, 0);
    chk("flush_ok", ok, 0);
    collect("after_flush_9div3");
    retire("after_flush_9div3");
    issue(0, 1, 1000, 10, 100);
    collect("hold_1000div10");
    held = res;
    repeat (5) begin
      @(negedge clk);
      chk("hold_ok", ok, 1);
      chk("hold_result", res, held);
    end
    bus.div_ack = 1'b1;
    @(negedge clk);
    bus.div_ack = 1'b0;
    chk("ack_req_hi_ok", ok, 0);
    chk("ack_req_hi_idle", bus.div_busy, 0);
    sb.push_back(32'd100);
    lq.push_back(lat_of(1, 1000, 10));
    collect("b2b_reaccept");
    retire("b2b_reaccept");
    issue(0, 1, 5, 9, 0);
    collect("small_div");
    retire("small_div");
    issue(1, 1, 5, 9, 5);
    collect("small_mod");
    retire("small_mod");
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      rm = 1'($urandom);
      ru = 1'($urandom);
      issue(rm, ru, ra, rb, model(rm, ru, ra, rb));
      collect("rand");
      retire("rand");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
